// File: rtl/rdtype_pkg.sv
// rdtype_checker shared types: FSM state encoding and SampleCount width.
package rdtype_pkg;

    localparam int SCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/rdtype_checker_if.sv
// Signal bundle between a register-under-test harness and rdtype_checker.
interface rdtype_checker_if
    import rdtype_pkg::*;
#(
    parameter int ERR_W = 8
);
    logic              Start;
    logic              D;
    logic              Q;
    logic              nQ;
    logic              Busy;
    logic              Pass;
    logic              Fail;
    logic [ERR_W-1:0]  ErrCount;
    logic [SCNT_W-1:0] SampleCount;
    logic [SCNT_W-1:0] FirstErr;

    modport master (
        output Start, D, Q, nQ,
        input  Busy, Pass, Fail, ErrCount, SampleCount, FirstErr
    );

    modport slave (
        input  Start, D, Q, nQ,
        output Busy, Pass, Fail, ErrCount, SampleCount, FirstErr
    );
endinterface

// File: rtl/rdtype_cmp.sv
// Holds the previously applied D and flags when Q/nQ disagree with it.
module rdtype_cmp (
    input  logic Clk,
    input  logic nRst,
    input  logic load,
    input  logic D,
    input  logic Q,
    input  logic nQ,
    output logic mismatch
);

    logic d_prev;

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            d_prev <= 1'b0;
        end else if (load) begin
            d_prev <= D;
        end
    end

    // Both outputs wrong on one edge still yields a single flag.
    assign mismatch = (Q != d_prev) || (nQ != ~d_prev);

endmodule

// File: rtl/rdtype_checker.sv
// Run-based checker for a D-type register with true/complement outputs.
// Optional FirstErr capture: define RDTYPE_CHECKER_FIRSTERR_EN.
module rdtype_checker
    import rdtype_pkg::*;
#(
    parameter int NCHECK = 100,
    parameter int ERR_W  = 8
) (
    input  logic              Clk,
    input  logic              nRst,
    input  logic              Start,
    input  logic              D,
    input  logic              Q,
    input  logic              nQ,
    output logic              Busy,
    output logic              Pass,
    output logic              Fail,
    output logic [ERR_W-1:0]  ErrCount,
    output logic [SCNT_W-1:0] SampleCount,
    output logic [SCNT_W-1:0] FirstErr
);

    state_t state;
    state_t nxt;
    logic   go;
    logic   load;
    logic   hit;
    logic   last;
    logic   mismatch;

    rdtype_cmp u_cmp (
        .Clk      (Clk),
        .nRst     (nRst),
        .load     (load),
        .D        (D),
        .Q        (Q),
        .nQ       (nQ),
        .mismatch (mismatch)
    );

    assign last = (SampleCount == SCNT_W'(NCHECK - 1));

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (Start) nxt = ARM;
            ARM:     nxt = CHECK;
            CHECK:   if (last) nxt = DONE;
            DONE:    if (Start) nxt = ARM;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        go   = 1'b0;
        load = 1'b0;
        hit  = 1'b0;
        Busy = 1'b0;
        Pass = 1'b0;
        Fail = 1'b0;
        unique case (state)
            IDLE: go = Start;
            ARM: begin
                load = 1'b1;
                Busy = 1'b1;
            end
            CHECK: begin
                load = 1'b1;
                Busy = 1'b1;
                hit  = mismatch;
            end
            DONE: begin
                go   = Start;
                Pass = (ErrCount == '0);
                Fail = (ErrCount != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            ErrCount    <= '0;
            SampleCount <= '0;
        end else if (go) begin
            ErrCount    <= '0;
            SampleCount <= '0;
        end else if (state == CHECK) begin
            SampleCount <= SampleCount + 1'b1;
            if (hit && ErrCount != '1) begin
                ErrCount <= ErrCount + 1'b1;
            end
        end
    end

`ifdef RDTYPE_CHECKER_FIRSTERR_EN
    logic [SCNT_W-1:0] first_q;

    // A zero ErrCount means no mismatch yet this run; it never wraps back.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            first_q <= '0;
        end else if (go) begin
            first_q <= '0;
        end else if (hit && ErrCount == '0) begin
            first_q <= SampleCount;
        end
    end

    assign FirstErr = first_q;
`else
    assign FirstErr = '0;
`endif

endmodule

// File: tb/tb_rdtype_checker.sv
// Self-checking bench for rdtype_checker (NCHECK=8, ERR_W=8 and ERR_W=2).
module tb_rdtype_checker;

`ifdef RDTYPE_CHECKER_FIRSTERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    localparam int N = 8;

    logic Clk;
    logic nRst;

    rdtype_checker_if #(.ERR_W(8)) t0 ();
    rdtype_checker_if #(.ERR_W(2)) t1 ();

    assign t1.Start = t0.Start;
    assign t1.D     = t0.D;
    assign t1.Q     = t0.Q;
    assign t1.nQ    = t0.nQ;

    rdtype_checker #(.NCHECK(N), .ERR_W(8)) dut0 (
        .Clk         (Clk),
        .nRst        (nRst),
        .Start       (t0.Start),
        .D           (t0.D),
        .Q           (t0.Q),
        .nQ          (t0.nQ),
        .Busy        (t0.Busy),
        .Pass        (t0.Pass),
        .Fail        (t0.Fail),
        .ErrCount    (t0.ErrCount),
        .SampleCount (t0.SampleCount),
        .FirstErr    (t0.FirstErr)
    );

    rdtype_checker #(.NCHECK(N), .ERR_W(2)) dut1 (
        .Clk         (Clk),
        .nRst        (nRst),
        .Start       (t1.Start),
        .D           (t1.D),
        .Q           (t1.Q),
        .nQ          (t1.nQ),
        .Busy        (t1.Busy),
        .Pass        (t1.Pass),
        .Fail        (t1.Fail),
        .ErrCount    (t1.ErrCount),
        .SampleCount (t1.SampleCount),
        .FirstErr    (t1.FirstErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    logic dv  [0:N];
    logic qv  [0:N-1];
    logic nqv [0:N-1];
    int   busy_seen;

    typedef struct {
        string name;
        int    mode;
        int    pass;
        int    fail;
        int    err8;
        int    err2;
        int    scnt;
        int    fe;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // modes: 0 ideal, 1 Q stuck 0 with D=1, 2 nQ=Q on compare 3,
    // 3 both outputs wrong on compare 5, 4 ideal + Start at compare 2,
    // 5 random data and random faults
    task automatic run(input int mode);
        logic q;
        logic nq;
        for (int k = 0; k <= N; k++) begin
            if (mode == 1)      dv[k] = 1'b1;
            else if (mode == 5) dv[k] = 1'($urandom_range(0, 1));
            else                dv[k] = 1'(k % 2);
        end
        t0.Start = 1'b1;
        t0.D = 1'b0;
        t0.Q = 1'b0;
        t0.nQ = 1'b1;
        step();
        t0.Start = 1'b0;
        busy_seen = 0;
        t0.D = dv[0];
        if (t0.Busy) busy_seen++;
        step();
        for (int i = 0; i < N; i++) begin
            q  = dv[i];
            nq = ~dv[i];
            case (mode)
                1: begin q = 1'b0; nq = 1'b1; end
                2: if (i == 3) nq = q;
                3: if (i == 5) begin q = ~q; nq = ~nq; end
                5: begin
                    if ($urandom_range(0, 3) == 0) q = ~q;
                    if ($urandom_range(0, 3) == 0) nq = ~nq;
                end
                default: ;
            endcase
            t0.Start = (mode == 4 && i == 2);
            t0.D  = dv[i + 1];
            t0.Q  = q;
            t0.nQ = nq;
            qv[i]  = q;
            nqv[i] = nq;
            if (t0.Busy) busy_seen++;
            step();
        end
        t0.Start = 1'b0;
    endtask

    task automatic check_done(input string nm, input int pass, input int fail,
                              input int e8, input int e2, input int scnt,
                              input int fe);
        chk({nm, ".busy_cycles"}, busy_seen, 9);
        chk({nm, ".busy_done"}, t0.Busy, 0);
        chk({nm, ".pass"}, t0.Pass, pass);
        chk({nm, ".fail"}, t0.Fail, fail);
        chk({nm, ".errcount"}, t0.ErrCount, e8);
        chk({nm, ".errcount_w2"}, t1.ErrCount, e2);
        chk({nm, ".fail_w2"}, t1.Fail, (e2 != 0));
        chk({nm, ".samplecount"}, t0.SampleCount, scnt);
        chk({nm, ".firsterr"}, t0.FirstErr, FE_EN ? fe : 0);
    endtask

    // Reference: compare i checks Q/nQ against the D applied one edge earlier.
    task automatic model_check(input string nm);
        int errs;
        int fe;
        bit seen;
        errs = 0;
        fe = 0;
        seen = 0;
        for (int i = 0; i < N; i++) begin
            if (qv[i] !== dv[i] || nqv[i] !== ~dv[i]) begin
                if (!seen) fe = i;
                seen = 1;
                errs++;
            end
        end
        check_done(nm, (errs == 0), (errs != 0), (errs > 255) ? 255 : errs,
                   (errs > 3) ? 3 : errs, N, fe);
    endtask

    initial begin
        tbl[0] = '{"ideal",    0, 1, 0, 0, 0, N, 0};
        tbl[1] = '{"stuck",    1, 0, 1, 8, 3, N, 0};
        tbl[2] = '{"nq_eq_q3", 2, 0, 1, 1, 1, N, 3};
        tbl[3] = '{"both5",    3, 0, 1, 1, 1, N, 5};
        tbl[4] = '{"start_mid",4, 1, 0, 0, 0, N, 0};

        nRst = 1'b0;
        t0.Start = 1'b0;
        t0.D = 1'b0;
        t0.Q = 1'b0;
        t0.nQ = 1'b1;
        #1;
        chk("rst.busy", t0.Busy, 0);
        chk("rst.pass", t0.Pass, 0);
        chk("rst.fail", t0.Fail, 0);
        chk("rst.errcount", t0.ErrCount, 0);
        chk("rst.samplecount", t0.SampleCount, 0);
        step();
        nRst = 1'b1;
        step();
        step();
        chk("idle.busy", t0.Busy, 0);
        chk("idle.pass", t0.Pass, 0);

        for (int v = 0; v < 5; v++) begin
            run(tbl[v].mode);
            check_done(tbl[v].name, tbl[v].pass, tbl[v].fail, tbl[v].err8,
                       tbl[v].err2, tbl[v].scnt, tbl[v].fe);
            if (v == 1) begin
                step();
                step();
                step();
                chk("hold.fail", t0.Fail, 1);
                chk("hold.errcount", t0.ErrCount, 8);
                chk("hold.busy", t0.Busy, 0);
            end
        end

        // Reset pulse mid-run after compare 4.
        t0.Start = 1'b1;
        step();
        t0.Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            t0.D  = 1'(i % 2);
            t0.Q  = 1'(i % 2 == 0);
            t0.nQ = 1'(i % 2 != 0);
            step();
        end
        chk("midrun.samplecount", t0.SampleCount, 4);
        nRst = 1'b0;
        #2;
        chk("rstpulse.busy", t0.Busy, 0);
        chk("rstpulse.pass", t0.Pass | t0.Fail, 0);
        chk("rstpulse.errcount", t0.ErrCount, 0);
        chk("rstpulse.samplecount", t0.SampleCount, 0);
        chk("rstpulse.firsterr", t0.FirstErr, 0);
        #3;
        nRst = 1'b1;
        step();
        step();
        step();
        chk("postrst.busy", t0.Busy, 0);
        chk("postrst.passfail", t0.Pass | t0.Fail, 0);
        chk("postrst.samplecount", t0.SampleCount, 0);
        run(0);
        check_done("after_rst", 1, 0, 0, 0, N, 0);

        for (int r = 0; r < 20; r++) begin
            run(5);
            model_check($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
